// File: rtl/eth_rx_pattern_checker.sv
// eth_rx_pattern_checker: MAC-filtered Ethernet RX sink that checks type, length, sequence and incrementing payload.
// Defining CHECKER_STALL_EN adds LFSR-driven payload backpressure for upstream stress testing.
module eth_rx_pattern_checker #(
  parameter int          LENGTH     = 512,
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_00,
  parameter logic [15:0] ETH_TYPE   = 16'h88B5,
  parameter int          DATA_WIDTH = 8,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic [CNT_WIDTH-1:0]  good_cnt,
  output logic [CNT_WIDTH-1:0]  bad_cnt,
  output logic [CNT_WIDTH-1:0]  filtered_cnt,
  output logic [CNT_WIDTH-1:0]  seq_gap_cnt,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [3:0]            err_code
);
  localparam logic [15:0] LAST = 16'(LENGTH - 1);
  typedef enum logic [1:0] {IDLE, CHECK, DROP} state_t;
  state_t state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] seq_q, seq_d, exp_seq_q, exp_seq_d;
  logic over_q, over_d, hdr_ready_q, hdr_ready_d, tready_q, tready_d;
  logic frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic [3:0] ferr_q, ferr_d, err_code_q, err_code_d, beat_err;
  logic [CNT_WIDTH-1:0] good_q, good_d, bad_q, bad_d, filt_q, filt_d, gap_q, gap_d;
  logic beat, at_last, mac_ok, stall, unused;
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
  assign unused  = ^s_eth_src_mac;
  assign beat    = s_eth_payload_axis_tvalid & tready_q;
  assign at_last = idx_q == LAST;
  assign mac_ok  = s_eth_dest_mac == LOCAL_MAC || &s_eth_dest_mac;
  // Bytes past the saturated index are only consumed, never pattern-checked.
  assign beat_err = {s_eth_payload_axis_tlast & s_eth_payload_axis_tuser,
                     idx_q != 16'd0 && !over_q &&
                       s_eth_payload_axis_tdata != seq_q + idx_q[DATA_WIDTH-1:0],
                     s_eth_payload_axis_tlast ^ at_last,
                     1'b0};
`ifdef CHECKER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign stall  = lfsr_d[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= 16'hACE1;
    else lfsr_q <= lfsr_d;
`else
  assign stall = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seq_d        = seq_q;
    exp_seq_d    = exp_seq_q;
    over_d       = over_q;
    ferr_d       = ferr_q;
    err_code_d   = err_code_q;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    good_d       = good_q;
    bad_d        = bad_q;
    filt_d       = filt_q;
    gap_d        = gap_q;
    case (state_q)
      IDLE: if (s_eth_hdr_valid && hdr_ready_q) begin
        state_d = mac_ok ? CHECK : DROP;
        idx_d   = 16'd0;
        over_d  = 1'b0;
        ferr_d  = {3'b000, s_eth_type != ETH_TYPE};
      end
      CHECK: if (beat) begin
        ferr_d = ferr_q | beat_err;
        idx_d  = at_last ? idx_q : idx_q + 16'd1;
        over_d = over_q | (at_last & ~s_eth_payload_axis_tlast);
        if (idx_q == 16'd0) begin
          seq_d     = s_eth_payload_axis_tdata;
          exp_seq_d = s_eth_payload_axis_tdata + 1'b1;
          gap_d     = s_eth_payload_axis_tdata != exp_seq_q ? sat_inc(gap_q) : gap_q;
        end
        if (s_eth_payload_axis_tlast) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          frame_ok_d   = ~|ferr_d;
          good_d       = ~|ferr_d ? sat_inc(good_q) : good_q;
          bad_d        = |ferr_d ? sat_inc(bad_q) : bad_q;
          err_code_d   = err_code_q | ferr_d;
        end
      end
      DROP: if (beat && s_eth_payload_axis_tlast) begin
        state_d = IDLE;
        filt_d  = sat_inc(filt_q);
      end
      default: state_d = IDLE;
    endcase
    hdr_ready_d = state_d == IDLE;
    tready_d    = state_d != IDLE && !stall;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      seq_q        <= '0;
      exp_seq_q    <= '0;
      over_q       <= 1'b0;
      ferr_q       <= '0;
      err_code_q   <= '0;
      hdr_ready_q  <= 1'b0;
      tready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      good_q       <= '0;
      bad_q        <= '0;
      filt_q       <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      seq_q        <= seq_d;
      exp_seq_q    <= exp_seq_d;
      over_q       <= over_d;
      ferr_q       <= ferr_d;
      err_code_q   <= err_code_d;
      hdr_ready_q  <= hdr_ready_d;
      tready_q     <= tready_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      filt_q       <= filt_d;
      gap_q        <= gap_d;
    end
  assign s_eth_hdr_ready           = hdr_ready_q;
  assign s_eth_payload_axis_tready = tready_q;
  assign good_cnt                  = good_q;
  assign bad_cnt                   = bad_q;
  assign filtered_cnt              = filt_q;
  assign seq_gap_cnt               = gap_q;
  assign frame_done                = frame_done_q;
  assign frame_ok                  = frame_ok_q;
  assign err_code                  = err_code_q;
endmodule

// File: tb/tb_eth_rx_pattern_checker.sv
// tb_eth_rx_pattern_checker: directed frames against eth_rx_pattern_checker with a per-frame result scoreboard.
module tb_eth_rx_pattern_checker;
  localparam int          LEN   = 512;
  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_00;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [15:0] TYPE  = 16'h88B5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic hdr_valid = 1'b0, hdr_ready;
  logic [47:0] dest_mac = '0, src_mac = 48'hDE_AD_BE_EF_00_01;
  logic [15:0] eth_type = '0;
  logic [7:0] tdata = '0;
  logic tvalid = 1'b0, tready, tlast = 1'b0, tuser = 1'b0;
  logic [31:0] good_cnt, bad_cnt, filtered_cnt, seq_gap_cnt;
  logic frame_done, frame_ok;
  logic [3:0] err_code;
  typedef struct packed {logic ok; logic [3:0] err;} exp_t;
  exp_t sb[$];
  int asserts = 0, fails = 0, stalls = 0, done_cnt = 0, s0;
  int m_good = 0, m_bad = 0, m_filt = 0, m_gap = 0, m_done = 0;
  logic [3:0] m_err = '0;
  logic [7:0] m_seq = '0;
  eth_rx_pattern_checker dut (
    .clk(clk), .rst_n(rst_n),
    .s_eth_hdr_valid(hdr_valid), .s_eth_hdr_ready(hdr_ready),
    .s_eth_dest_mac(dest_mac), .s_eth_src_mac(src_mac), .s_eth_type(eth_type),
    .s_eth_payload_axis_tdata(tdata), .s_eth_payload_axis_tvalid(tvalid),
    .s_eth_payload_axis_tready(tready), .s_eth_payload_axis_tlast(tlast),
    .s_eth_payload_axis_tuser(tuser),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt), .filtered_cnt(filtered_cnt),
    .seq_gap_cnt(seq_gap_cnt), .frame_done(frame_done), .frame_ok(frame_ok),
    .err_code(err_code)
  );
  always #4 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && frame_done) begin
      done_cnt++;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("frame_ok", frame_ok, e.ok);
        chk("err_code_at_done", err_code, e.err);
      end
    end
  task automatic send_frame(input logic [47:0] mac, input logic [15:0] typ, input logic [7:0] seq,
                            input int len, input int corrupt, input logic bad_user, input int abort_at);
    int t;
    logic [3:0] e;
    exp_t item;
    if (abort_at < 0) begin
      if (mac == LOCAL || &mac) begin
        e = {bad_user, corrupt > 0 && corrupt < len && corrupt < LEN, len != LEN, typ != TYPE};
        if (seq != m_seq) m_gap++;
        m_seq = seq + 8'd1;
        m_err |= e;
        if (e == 4'd0) m_good++; else m_bad++;
        item.ok = e == 4'd0;
        item.err = m_err;
        sb.push_back(item);
        m_done++;
      end else m_filt++;
    end
    hdr_valid = 1'b1;
    dest_mac = mac;
    eth_type = typ;
    t = 0;
    while (!hdr_ready && t < 1000) begin @(negedge clk); t++; end
    chk("hdr_wait_bound", t < 1000, 1);
    @(negedge clk);
    hdr_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (abort_at >= 0 && i == abort_at) begin
        tvalid = 1'b0;
        return;
      end
      tdata = (i == corrupt) ? 8'h00 : seq + 8'(i);
      tvalid = 1'b1;
      tlast = i == len - 1;
      tuser = bad_user && i == len - 1;
      t = 0;
      while (!tready && t < 1000) begin stalls++; @(negedge clk); t++; end
      if (t >= 1000) begin chk("tready_wait_bound", t, 0); return; end
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast = 1'b0;
    tuser = 1'b0;
    @(negedge clk);
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_good"}, good_cnt, m_good);
    chk({tag, "_bad"}, bad_cnt, m_bad);
    chk({tag, "_filt"}, filtered_cnt, m_filt);
    chk({tag, "_gap"}, seq_gap_cnt, m_gap);
    chk({tag, "_err"}, err_code, m_err);
    chk({tag, "_done"}, done_cnt, m_done);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_idle"}, hdr_ready, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hdr_ready", hdr_ready, 0);
    chk("rst_tready", tready, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", err_code, 0);
    chk("rst_cnts", {good_cnt, bad_cnt} | {filtered_cnt, seq_gap_cnt}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hdr_ready", hdr_ready, 1);
    chk("idle_no_tready", tready, 0);
    // three clean frames
    for (int s = 0; s < 3; s++) send_frame(LOCAL, TYPE, 8'(s), LEN, -1, 1'b0, -1);
    check_all("s1");
    // corrupted data, then a clean frame
    send_frame(LOCAL, TYPE, 8'd3, LEN, 100, 1'b0, -1);
    check_all("s2_bad");
    chk("s2_frame_ok_held", frame_ok, 0);
    chk("s2_err_code", err_code, 4'b0100);
    send_frame(LOCAL, TYPE, 8'd4, LEN, -1, 1'b0, -1);
    check_all("s2_clean");
    chk("s2_err_sticky", err_code, 4'b0100);
    // short and long frames
    send_frame(LOCAL, TYPE, 8'd5, 300, -1, 1'b0, -1);
    check_all("s3_short");
    send_frame(LOCAL, TYPE, 8'd6, 600, -1, 1'b0, -1);
    check_all("s3_long");
    chk("s3_err_code", err_code, 4'b0110);
    // filtered and broadcast frames
    s0 = stalls;
    send_frame(OTHER, TYPE, 8'd7, LEN, -1, 1'b0, -1);
    check_all("s4_drop");
`ifndef CHECKER_STALL_EN
    chk("s4_drop_tready_held", stalls - s0, 0);
`endif
    send_frame(BCAST, TYPE, 8'd7, LEN, -1, 1'b0, -1);
    check_all("s4_bcast");
    // type error, tuser error, sequence gap and wrap
    send_frame(LOCAL, 16'h0800, 8'd8, LEN, -1, 1'b0, -1);
    send_frame(LOCAL, TYPE, 8'd9, LEN, -1, 1'b1, -1);
    check_all("s5_type_user");
    chk("s5_err_code", err_code, 4'b1111);
    send_frame(LOCAL, TYPE, 8'd10, LEN, -1, 1'b0, -1);
    send_frame(LOCAL, TYPE, 8'd11, LEN, -1, 1'b0, -1);
    send_frame(LOCAL, TYPE, 8'd13, LEN, -1, 1'b0, -1);
    check_all("s5_gap");
    send_frame(LOCAL, TYPE, 8'd255, LEN, -1, 1'b0, -1);
    send_frame(LOCAL, TYPE, 8'd0, LEN, -1, 1'b0, -1);
    check_all("s5_wrap");
    // reset in the middle of a frame
    send_frame(LOCAL, TYPE, 8'd1, LEN, -1, 1'b0, 200);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_good", good_cnt, 0);
    chk("s6_rst_bad", bad_cnt, 0);
    chk("s6_rst_gap", seq_gap_cnt, 0);
    chk("s6_rst_err", err_code, 0);
    chk("s6_rst_tready", tready, 0);
    m_good = 0; m_bad = 0; m_filt = 0; m_gap = 0; m_err = '0; m_seq = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(LOCAL, TYPE, 8'd0, LEN, -1, 1'b0, -1);
    check_all("s6_after");
`ifdef CHECKER_STALL_EN
    chk("stall_seen", stalls > 0, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
